reaction_datapath: RTL

//   Datapath for the reaction timer. Consumes the 2-bit state code (en) from the timer control FSM.

---
 rtl/reaction_datapath.sv | 125 ++++++++++++
 1 files changed

// File: rtl/reaction_datapath.sv
// reaction_datapath: datapath for the reaction timer.
// Turns the control FSM's 2-bit state code into a 1 ms tick, a pseudo-random
// countdown delay, a countdown_finish flag back to the FSM, and the measured
// reaction time, which is held for display.
// Optional feature: define REACTION_BEST_EN to build the best-time register.
// Without it, best_ms is tied to zero.
// lfsr_state exposes the LFSR register for observation.
`timescale 1ns/1ps

module reaction_datapath #(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          MAX_MS       = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  en,
  output logic        countdown_finish,
  output logic        go_led,
  output logic [13:0] time_ms,
  output logic        overflow,
  output logic [13:0] best_ms,
  output logic [15:0] lfsr_state
);

  localparam int             TICK_DIV = CLK_HZ / 1000;
  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [13:0]    MAX_T    = 14'(MAX_MS);
  localparam logic [11:0]    MIN_D    = 12'(MIN_DELAY_MS);

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_COUNTDOWN = 2'b01;
  localparam logic [1:0] ST_REACTION  = 2'b10;
  localparam logic [1:0] ST_DISPLAY   = 2'b11;

  logic [1:0]    en_prev;
  logic [PW-1:0] prescaler;
  logic [15:0]   lfsr;
  logic [11:0]   delay;
  logic          entry;
  logic          tick;
  logic          lfsr_fb;

  // Any change of state code is an entry; the tick fires on the prescaler wrap.
  assign entry      = (en != en_prev);
  assign tick       = (prescaler == PRE_LAST);
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_state = lfsr;

  // Remember last state code for entry detection (reset to IDLE so the first 01 is an entry).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) en_prev <= ST_IDLE;
    else          en_prev <= en;
  end

  // Millisecond prescaler; restarts on every entry so each phase begins with a full ms.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   prescaler <= '0;
    else if (entry) prescaler <= '0;
    else if (tick)  prescaler <= '0;
    else            prescaler <= prescaler + 1'b1;
  end

  // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Countdown delay: loaded on COUNTDOWN entry, decremented per tick, cleared outside COUNTDOWN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      delay <= '0;
    end else if (en == ST_COUNTDOWN) begin
      if (entry)                    delay <= MIN_D + {1'b0, lfsr[10:0]};
      else if (tick && delay != '0) delay <= delay - 12'd1;
    end else begin
      delay <= '0;
    end
  end

  // countdown_finish: set once an expired delay is seen in COUNTDOWN, dropped when COUNTDOWN is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                countdown_finish <= 1'b0;
    else if (en != ST_COUNTDOWN) countdown_finish <= 1'b0;
    else if (entry)              countdown_finish <= 1'b0;
    else if (delay == '0)        countdown_finish <= 1'b1;
  end

  // Stimulus LED follows the REACTION state one cycle late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) go_led <= 1'b0;
    else          go_led <= (en == ST_REACTION);
  end

  // Reaction counter: cleared on COUNTDOWN/REACTION entry, counts ms in REACTION, saturates at MAX_MS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_ms  <= '0;
      overflow <= 1'b0;
    end else if (entry && (en == ST_COUNTDOWN || en == ST_REACTION)) begin
      time_ms  <= '0;
      overflow <= 1'b0;
    end else if (en == ST_REACTION && tick) begin
      if (time_ms == MAX_T) overflow <= 1'b1;
      else                  time_ms  <= time_ms + 14'd1;
    end
  end

`ifdef REACTION_BEST_EN
  // Best time: captured on DISPLAY entry when the run is valid and faster; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_ms <= MAX_T;
    end else if (entry && en == ST_DISPLAY && !overflow && time_ms < best_ms) begin
      best_ms <= time_ms;
    end
  end
`else
  assign best_ms = 14'd0;
`endif

endmodule
